// File: rtl/zero_detector_stim_serializer.sv
// Parallel-to-serial front end for the Mealy zero detector: valid/ready word in, one bit per clock out.
// Optional trailing even-parity bit per word when ZERO_DET_SER_PARITY_EN is defined.
module zero_detector_stim_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef ZERO_DET_SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               x_out_q, x_out_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               load;
  logic               go_idle;
  logic               load_bit;
  logic [WIDTH-1:0]   load_rest;
  logic               next_bit;
  logic [WIDTH-1:0]   next_rest;
`ifdef ZERO_DET_SER_PARITY_EN
  logic               parity_q, parity_d;
`endif

  // Bit ordering: x_out holds the bit on the wire, shreg holds the bits still to send.
  always_comb begin
    if (MSB_FIRST) begin
      load_bit  = din[WIDTH-1];
      load_rest = din << 1;
      next_bit  = shreg_q[WIDTH-1];
      next_rest = shreg_q << 1;
    end else begin
      load_bit  = din[0];
      load_rest = din >> 1;
      next_bit  = shreg_q[0];
      next_rest = shreg_q >> 1;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    din_ready = 1'b0;
    load      = 1'b0;
    go_idle   = 1'b0;
`ifdef ZERO_DET_SER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE:   din_ready = 1'b1;
`ifdef ZERO_DET_SER_PARITY_EN
      ST_SHIFT:  din_ready = 1'b0;
      ST_PARITY: din_ready = 1'b1;
`else
      ST_SHIFT:  din_ready = (cnt_q == '0);
`endif
      default:   din_ready = 1'b0;
    endcase
    if (rst) din_ready = 1'b0;
    accept = din_valid && din_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
        else        go_idle = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          x_out_d = next_bit;
          shreg_d = next_rest;
          cnt_d   = cnt_q - CNT_W'(1);
`ifndef ZERO_DET_SER_PARITY_EN
          done_d  = (cnt_q == CNT_W'(1));
`endif
        end else begin
`ifdef ZERO_DET_SER_PARITY_EN
          state_d = ST_PARITY;
          x_out_d = parity_q;
          done_d  = 1'b1;
`else
          if (accept) load = 1'b1;
          else        go_idle = 1'b1;
`endif
        end
      end
`ifdef ZERO_DET_SER_PARITY_EN
      ST_PARITY: begin
        if (accept) load = 1'b1;
        else        go_idle = 1'b1;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (load) begin
      state_d   = ST_SHIFT;
      shreg_d   = load_rest;
      cnt_d     = CNT_W'(WIDTH - 1);
      x_out_d   = load_bit;
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
`ifdef ZERO_DET_SER_PARITY_EN
      parity_d  = ^din;
`endif
    end else if (go_idle) begin
      state_d   = ST_IDLE;
      x_out_d   = IDLE_BIT;
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
    end
  end

  // State and output registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      x_out_q   <= IDLE_BIT;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ZERO_DET_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ZERO_DET_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_zero_detector_stim_serializer.sv
// Scoreboard bench for zero_detector_stim_serializer: MSB-first and LSB-first instances, WIDTH=8.
module tb_zero_detector_stim_serializer;

  localparam logic IDLE = 1'b1;

  typedef struct packed {
    logic b;
    logic d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready, x_out, x_valid, busy, done;
  logic [7:0] ldin = '0;
  logic       ldin_valid = 1'b0;
  logic       ldin_ready, lx_out, lx_valid, lbusy, ldone;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q[$];
  exp_t ql[$];

  always #5 clk = ~clk;

  zero_detector_stim_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
  );

  zero_detector_stim_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_lsb (
    .clk(clk), .rst(rst), .din(ldin), .din_valid(ldin_valid), .din_ready(ldin_ready),
    .x_out(lx_out), .x_valid(lx_valid), .busy(lbusy), .done(ldone)
  );

  // Expected serial sequence of one accepted word, appended to the chosen queue.
  function automatic void push_word(input logic [7:0] d, input bit lsb);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = lsb ? d[i] : d[7-i];
`ifdef ZERO_DET_SER_PARITY_EN
      e.d = 1'b0;
`else
      e.d = (i == 7);
`endif
      if (lsb) ql.push_back(e); else q.push_back(e);
    end
`ifdef ZERO_DET_SER_PARITY_EN
    e.b = ^d;
    e.d = 1'b1;
    if (lsb) ql.push_back(e); else q.push_back(e);
`endif
  endfunction

  task automatic test_reset();
    logic [4:0] obs, exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {x_valid, x_out, done, busy, din_ready};
    exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp) $display("FAIL reset_state: got %b exp %b (valid,x,done,busy,ready)", obs, exp);
    else n_pass++;
    rst = 1'b0;
    q.delete();
    ql.delete();
    @(negedge clk);
    obs = {x_valid, x_out, done, busy, din_ready};
    exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp) $display("FAIL reset_release: got %b exp %b (valid,x,done,busy,ready)", obs, exp);
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [4:0] obs, exp;
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      obs = {x_valid, x_out, done, busy, din_ready};
      if (q.size() != 0) begin
        e = q.pop_front();
        exp = {1'b1, e.b, e.d, 1'b1, (q.size() == 0)};
      end else exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (obs !== exp) $display("FAIL single_word cyc %0d: got %b exp %b", c, obs, exp);
      else n_pass++;
      din_valid = (c == 0);
      din = (c == 0) ? 8'hA5 : 8'h5A;
      if (din_valid && q.size() == 0) push_word(din, 1'b0);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs, exp;
    exp_t e;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      obs = {x_valid, x_out, done, busy, din_ready};
      if (q.size() != 0) begin
        e = q.pop_front();
        exp = {1'b1, e.b, e.d, 1'b1, (q.size() == 0)};
      end else exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (obs !== exp) $display("FAIL back_to_back cyc %0d: got %b exp %b", c, obs, exp);
      else n_pass++;
`ifdef ZERO_DET_SER_PARITY_EN
      din_valid = (c == 0) || (c == 9);
`else
      din_valid = (c == 0) || (c == 8);
`endif
      din = (c == 0) ? 8'h00 : 8'hFF;
      if (din_valid && q.size() == 0) push_word(din, 1'b0);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_held_valid();
    logic [4:0] obs, exp;
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      obs = {x_valid, x_out, done, busy, din_ready};
      if (q.size() != 0) begin
        e = q.pop_front();
        exp = {1'b1, e.b, e.d, 1'b1, (q.size() == 0)};
      end else exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (obs !== exp) $display("FAIL held_valid cyc %0d: got %b exp %b", c, obs, exp);
      else n_pass++;
      din_valid = (c < 26);
      din = 8'(c * 59 + 1);
      if (din_valid && q.size() == 0) push_word(din, 1'b0);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] obs, exp;
    exp_t e;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obs = {x_valid, x_out, done, busy, din_ready};
      if (q.size() != 0) begin
        e = q.pop_front();
        exp = {1'b1, e.b, e.d, 1'b1, (q.size() == 0) && !rst};
      end else exp = {1'b0, IDLE, 1'b0, 1'b0, !rst};
      n_checks++;
      if (obs !== exp) $display("FAIL reset_mid_word cyc %0d: got %b exp %b", c, obs, exp);
      else n_pass++;
      rst = (c == 3);
      din_valid = (c == 0) || (c == 6);
      din = (c == 0) ? 8'hA5 : 8'h3C;
      if (rst) q.delete();
      else if (din_valid && q.size() == 0) push_word(din, 1'b0);
    end
    din_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [4:0] obs, exp;
    exp_t e;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      obs = {lx_valid, lx_out, ldone, lbusy, ldin_ready};
      if (ql.size() != 0) begin
        e = ql.pop_front();
        exp = {1'b1, e.b, e.d, 1'b1, (ql.size() == 0)};
      end else exp = {1'b0, IDLE, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (obs !== exp) $display("FAIL lsb_first cyc %0d: got %b exp %b", c, obs, exp);
      else n_pass++;
`ifdef ZERO_DET_SER_PARITY_EN
      ldin_valid = (c == 0) || (c == 9);
`else
      ldin_valid = (c == 0) || (c == 8);
`endif
      ldin = (c == 0) ? 8'h01 : 8'h96;
      if (ldin_valid && ql.size() == 0) push_word(ldin, 1'b1);
    end
    ldin_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_held_valid();
    test_reset_mid_word();
    test_lsb_first();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
